// File: rtl/tap_recorder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tap_recorder
// Description : Measures PET cassette write pulses at ce_1m resolution and
//               streams them as a TAP v1 image into memory through a
//               request/acknowledge byte write port.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
module tap_recorder #(
   parameter int ADDR_W    = 25,
   parameter int FIFO_AW   = 2,
   parameter int MIN_PULSE = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              ce_1m,
   input  logic              rec_start,
   input  logic              rec_stop,
   input  logic              cass_motor_n,
   input  logic              cass_write,
   output logic              wr_req,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   input  logic              wr_ack,
   output logic              busy,
   output logic [31:0]       rec_len,
   output logic              overflow,
   output logic              done
);

   localparam logic [2:0] c_IDLE  = 3'd0;
   localparam logic [2:0] c_HDR   = 3'd1;
   localparam logic [2:0] c_REC   = 3'd2;
   localparam logic [2:0] c_SHORT = 3'd3;
   localparam logic [2:0] c_LONG  = 3'd4;
   localparam logic [2:0] c_PATCH = 3'd5;
   localparam logic [2:0] c_DONE  = 3'd6;

   localparam int              c_DEPTH     = 1 << FIFO_AW;
   localparam logic [ADDR_W:0] c_LIMIT     = {1'b0, {ADDR_W{1'b1}}};
   localparam logic [23:0]     c_MIN_PULSE = 24'(MIN_PULSE);

   // TAP header byte at position idx (0..19); bytes 16..19 carry the record
   // length, written as zero here and filled in by the PATCH state
   function automatic logic [7:0] f_hdr(input logic [4:0] idx);
      logic [7:0] b;
      case (idx)
         5'd0:    b = 8'h43;
         5'd1:    b = 8'h36;
         5'd2:    b = 8'h34;
         5'd3:    b = 8'h2D;
         5'd4:    b = 8'h54;
         5'd5:    b = 8'h41;
         5'd6:    b = 8'h50;
         5'd7:    b = 8'h45;
         5'd8:    b = 8'h2D;
         5'd9:    b = 8'h52;
         5'd10:   b = 8'h41;
         5'd11:   b = 8'h57;
         5'd12:   b = 8'h01;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // Little-endian byte select out of a 32-bit word
   function automatic logic [7:0] f_sel(input logic [31:0] w, input logic [1:0] i);
      logic [7:0] b;
      case (i)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      return b;
   endfunction

   logic [2:0]        r_state;
   logic              r_wr_req;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [7:0]        r_wr_data;
   logic [31:0]       r_rec_len;
   logic              r_overflow;
   logic              r_done;
   logic              r_stop;
   logic [4:0]        r_idx;
   logic [ADDR_W-1:0] r_daddr;
   logic [23:0]       r_pulse;

   logic [23:0]       r_cnt;
   logic              r_first;
   logic              r_cass_prev;

   logic [23:0]       r_fifo [c_DEPTH];
   logic [FIFO_AW-1:0] r_wptr;
   logic [FIFO_AW-1:0] r_rptr;
   logic [FIFO_AW:0]   r_fcnt;

   logic              w_busy;
   logic              w_start;
   logic              w_meas;
   logic              w_edge;
   logic              w_cnt_ok;
   logic              w_full;
   logic              w_empty;
   logic              w_push_req;
   logic              w_push;
   logic              w_drop;
   logic              w_pop;
   logic [23:0]       w_head;
   logic [ADDR_W:0]   w_daddr_x;
   logic              w_short_fits;
   logic              w_long_fits;

   assign w_busy     = (r_state != c_IDLE);
   assign w_start    = (r_state == c_IDLE) && rec_start;
   // Measurement freezes once a stop is requested; an edge coinciding with
   // the stop pulse itself is discarded as well.
   assign w_meas     = ((r_state == c_HDR) || (r_state == c_REC) ||
                        (r_state == c_SHORT) || (r_state == c_LONG)) &&
                       !r_stop && !rec_stop;
   assign w_edge     = w_meas && r_cass_prev && !cass_write;
   assign w_cnt_ok   = (r_cnt >= c_MIN_PULSE);
   assign w_full     = (r_fcnt == (FIFO_AW+1)'(c_DEPTH));
   assign w_empty    = (r_fcnt == '0);
   assign w_push_req = w_edge && r_first && w_cnt_ok;
   assign w_push     = w_push_req && !w_full;
   assign w_drop     = w_push_req && w_full;
   assign w_pop      = (r_state == c_REC) && !w_empty;
   assign w_head     = r_fifo[r_rptr];

   // The last usable data address is 2^ADDR_W-2; compare one bit wider to avoid wrap
   assign w_daddr_x    = {1'b0, r_daddr};
   assign w_short_fits = (w_daddr_x < c_LIMIT);
   assign w_long_fits  = ((w_daddr_x + (ADDR_W+1)'(3)) < c_LIMIT);

   assign wr_req   = r_wr_req;
   assign wr_addr  = r_wr_addr;
   assign wr_data  = r_wr_data;
   assign busy     = w_busy;
   assign rec_len  = r_rec_len;
   assign overflow = r_overflow;
   assign done     = r_done;

   // Pulse-width counter with falling-edge detection on the write line
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt       <= '0;
         r_first     <= 1'b0;
         r_cass_prev <= 1'b0;
      end else begin
         r_cass_prev <= cass_write;
         if (w_start) begin
            r_cnt   <= '0;
            r_first <= 1'b0;
         end else if (w_busy && rec_stop) begin
            r_cnt <= '0;
         end else if (w_meas) begin
            if (w_edge && (!r_first || w_cnt_ok)) begin
               r_cnt   <= '0;
               r_first <= 1'b1;
            end else if (ce_1m && !cass_motor_n && (r_cnt != '1)) begin
               r_cnt <= r_cnt + 24'd1;
            end
         end
      end
   end

   // Pulse FIFO storage; contents are only meaningful between the pointers
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_wptr] <= r_cnt;
      end
   end

   // Pulse FIFO pointers and fill level
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_fcnt <= '0;
      end else if (w_start) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_fcnt <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_fcnt <= r_fcnt + 1'b1;
            2'b01:   r_fcnt <= r_fcnt - 1'b1;
            default: r_fcnt <= r_fcnt;
         endcase
      end
   end

   // Recording sequencer: header, pulse records, length patch and write port
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= c_IDLE;
         r_wr_req   <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
         r_rec_len  <= '0;
         r_overflow <= 1'b0;
         r_done     <= 1'b0;
         r_stop     <= 1'b0;
         r_idx      <= '0;
         r_daddr    <= '0;
         r_pulse    <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_drop) r_overflow <= 1'b1;
         if (w_busy && rec_stop) r_stop <= 1'b1;

         case (r_state)
            c_IDLE: begin
               if (rec_start) begin
                  r_state    <= c_HDR;
                  r_wr_req   <= 1'b1;
                  r_wr_addr  <= '0;
                  r_wr_data  <= f_hdr(5'd0);
                  r_idx      <= '0;
                  r_rec_len  <= '0;
                  r_overflow <= 1'b0;
                  r_stop     <= 1'b0;
                  r_daddr    <= ADDR_W'(20);
               end
            end

            c_HDR: begin
               if (r_wr_req) begin
                  if (wr_ack) begin
                     r_wr_req <= 1'b0;
                     if (r_idx == 5'd19) r_state <= c_REC;
                     else                r_idx   <= r_idx + 5'd1;
                  end
               end else begin
                  r_wr_req  <= 1'b1;
                  r_wr_addr <= ADDR_W'(r_idx);
                  r_wr_data <= f_hdr(r_idx);
               end
            end

            c_REC: begin
               if (w_pop) begin
                  r_pulse <= w_head;
                  r_idx   <= '0;
                  // A record that cannot fit below the address limit is dropped whole
                  if (w_head[23:11] == '0) begin
                     if (w_short_fits) r_state    <= c_SHORT;
                     else              r_overflow <= 1'b1;
                  end else begin
                     if (w_long_fits)  r_state    <= c_LONG;
                     else              r_overflow <= 1'b1;
                  end
               end else if (r_stop) begin
                  r_state <= c_PATCH;
                  r_idx   <= '0;
               end
            end

            c_SHORT: begin
               if (r_wr_req) begin
                  if (wr_ack) begin
                     r_wr_req  <= 1'b0;
                     r_rec_len <= r_rec_len + 32'd1;
                     r_daddr   <= r_daddr + 1'b1;
                     r_state   <= c_REC;
                  end
               end else begin
                  r_wr_req  <= 1'b1;
                  r_wr_addr <= r_daddr;
                  r_wr_data <= r_pulse[10:3];
               end
            end

            c_LONG: begin
               if (r_wr_req) begin
                  if (wr_ack) begin
                     r_wr_req  <= 1'b0;
                     r_rec_len <= r_rec_len + 32'd1;
                     r_daddr   <= r_daddr + 1'b1;
                     if (r_idx[1:0] == 2'd3) r_state <= c_REC;
                     else                    r_idx   <= r_idx + 5'd1;
                  end
               end else begin
                  r_wr_req  <= 1'b1;
                  r_wr_addr <= r_daddr;
                  // Long record: zero marker, then the 24-bit count little-endian
                  r_wr_data <= f_sel({r_pulse, 8'h00}, r_idx[1:0]);
               end
            end

            c_PATCH: begin
               if (r_wr_req) begin
                  if (wr_ack) begin
                     r_wr_req <= 1'b0;
                     if (r_idx[1:0] == 2'd3) begin
                        r_state <= c_DONE;
                        r_done  <= 1'b1;
                     end else begin
                        r_idx <= r_idx + 5'd1;
                     end
                  end
               end else begin
                  r_wr_req  <= 1'b1;
                  r_wr_addr <= ADDR_W'(r_idx) + ADDR_W'(5'd16);
                  r_wr_data <= f_sel(r_rec_len, r_idx[1:0]);
               end
            end

            c_DONE: begin
               r_state <= c_IDLE;
               r_stop  <= 1'b0;
            end

            default: begin
               r_state  <= c_IDLE;
               r_wr_req <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_tap_recorder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module      : tb_tap_recorder
// Description : Scoreboard bench for tap_recorder; expected memory writes are
//               queued by the stimulus and checked by an independent monitor.
// Revision    : 1.0 - initial release
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tap_recorder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        ce_1m;
   logic        rec_start;
   logic        rec_stop;
   logic        cass_motor_n;
   logic        cass_write;
   logic        wr_req;
   logic [24:0] wr_addr;
   logic [7:0]  wr_data;
   logic        wr_ack;
   logic        busy;
   logic [31:0] rec_len;
   logic        overflow;
   logic        done;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct packed {
      logic [24:0] a;
      logic [7:0]  d;
   } wr_t;

   wr_t exp_q[$];
   wr_t m_exp;

   logic [7:0] hdr_bytes [20] = '{8'h43, 8'h36, 8'h34, 8'h2D, 8'h54, 8'h41,
                                  8'h50, 8'h45, 8'h2D, 8'h52, 8'h41, 8'h57,
                                  8'h01, 8'h00, 8'h00, 8'h00,
                                  8'h00, 8'h00, 8'h00, 8'h00};

   tap_recorder #(
      .ADDR_W    (25),
      .FIFO_AW   (2),
      .MIN_PULSE (8)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .ce_1m        (ce_1m),
      .rec_start    (rec_start),
      .rec_stop     (rec_stop),
      .cass_motor_n (cass_motor_n),
      .cass_write   (cass_write),
      .wr_req       (wr_req),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_ack       (wr_ack),
      .busy         (busy),
      .rec_len      (rec_len),
      .overflow     (overflow),
      .done         (done)
   );

   always #5 clk = ~clk;

   // Monitor: every accepted write is popped from the scoreboard and compared
   always @(negedge clk) begin
      if (reset_n && wr_req && wr_ack) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_write: got addr %0d data %02h, required no write",
                     wr_addr, wr_data);
         end else begin
            m_exp = exp_q.pop_front();
            if ((m_exp.a !== wr_addr) || (m_exp.d !== wr_data)) begin
               n_err++;
               $display("FAIL mem_write: got addr %0d data %02h, required addr %0d data %02h",
                        wr_addr, wr_data, m_exp.a, m_exp.d);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic push_wr(input logic [24:0] a, input logic [7:0] d);
      wr_t t;
      t.a = a;
      t.d = d;
      exp_q.push_back(t);
   endtask

   task automatic push_hdr();
      for (int i = 0; i < 20; i++) push_wr(25'(i), hdr_bytes[i]);
   endtask

   task automatic push_patch(input logic [31:0] len);
      push_wr(25'd16, len[7:0]);
      push_wr(25'd17, len[15:8]);
      push_wr(25'd18, len[23:16]);
      push_wr(25'd19, len[31:24]);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         ce_1m = 1'b1;
         cyc(1);
         ce_1m = 1'b0;
         cyc(1);
      end
   endtask

   task automatic fall();
      cass_write = 1'b0;
      cyc(1);
      cass_write = 1'b1;
      cyc(1);
   endtask

   task automatic start_rec();
      rec_start = 1'b1;
      cyc(1);
      rec_start = 1'b0;
   endtask

   task automatic stop_rec();
      rec_stop = 1'b1;
      cyc(1);
      rec_stop = 1'b0;
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 200 && !seen; k++) begin
         if (done) seen = 1'b1;
         else      cyc(1);
      end
      check("done_seen", 32'(seen), 32'd1);
      if (seen) begin
         cyc(1);
         check("done_width", 32'(done), 32'd0);
         check("busy_after_done", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      bit seen;
      reset_n      = 1'b0;
      ce_1m        = 1'b0;
      rec_start    = 1'b0;
      rec_stop     = 1'b0;
      cass_motor_n = 1'b0;
      cass_write   = 1'b1;
      wr_ack       = 1'b1;
      cyc(3);
      check("rst_wr_req",   32'(wr_req),   32'd0);
      check("rst_wr_addr",  32'(wr_addr),  32'd0);
      check("rst_wr_data",  32'(wr_data),  32'd0);
      check("rst_busy",     32'(busy),     32'd0);
      check("rst_rec_len",  rec_len,       32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_done",     32'(done),     32'd0);
      reset_n = 1'b1;
      cyc(2);

      // Header, short pulses, a long pulse, a glitch, then stop and patch
      push_hdr();
      start_rec();
      check("hdr_req_latency", 32'(wr_req), 32'd1);
      cyc(45);
      check("busy_in_rec", 32'(busy), 32'd1);
      check("hdr_drained", 32'(exp_q.size()), 32'd0);

      fall();
      tick(400);
      push_wr(25'd20, 8'h32);
      fall();
      cyc(10);
      check("len_after_1", rec_len, 32'd1);
      tick(400);
      push_wr(25'd21, 8'h32);
      fall();
      cyc(10);
      check("len_after_2", rec_len, 32'd2);
      tick(3000);
      push_wr(25'd22, 8'h00);
      push_wr(25'd23, 8'hB8);
      push_wr(25'd24, 8'h0B);
      push_wr(25'd25, 8'h00);
      fall();
      cyc(20);
      check("len_after_long", rec_len, 32'd6);
      tick(5);
      fall();
      tick(395);
      push_wr(25'd26, 8'h32);
      fall();
      cyc(10);
      check("len_after_glitch", rec_len, 32'd7);
      push_patch(32'd7);
      stop_rec();
      wait_done();
      check("final_len_1", rec_len, 32'd7);
      check("final_ovf_1", 32'(overflow), 32'd0);
      check("drained_1", 32'(exp_q.size()), 32'd0);

      // Stalled write port: five intervals against a four-entry FIFO
      wr_ack = 1'b0;
      push_hdr();
      for (int i = 0; i < 4; i++) push_wr(25'(20 + i), 8'h32);
      start_rec();
      fall();
      for (int i = 0; i < 5; i++) begin
         tick(400);
         fall();
      end
      check("ovf_set", 32'(overflow), 32'd1);
      check("len_stalled", rec_len, 32'd0);
      wr_ack = 1'b1;
      cyc(100);
      check("len_after_ovf", rec_len, 32'd4);
      check("drained_2", 32'(exp_q.size()), 32'd0);
      push_patch(32'd4);
      stop_rec();
      wait_done();
      check("ovf_holds", 32'(overflow), 32'd1);

      // Reset while a long record is pending on the write port
      push_hdr();
      push_wr(25'd20, 8'h32);
      start_rec();
      cyc(45);
      fall();
      tick(400);
      fall();
      tick(2100);
      wr_ack = 1'b0;
      check("len_before_rst", rec_len, 32'd1);
      fall();
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (wr_req) seen = 1'b1;
         else        cyc(1);
      end
      check("long_req_seen", 32'(seen), 32'd1);
      check("long_req_addr", 32'(wr_addr), 32'd21);
      reset_n = 1'b0;
      #1;
      check("mid_rst_wr_req",   32'(wr_req),   32'd0);
      check("mid_rst_wr_addr",  32'(wr_addr),  32'd0);
      check("mid_rst_wr_data",  32'(wr_data),  32'd0);
      check("mid_rst_busy",     32'(busy),     32'd0);
      check("mid_rst_rec_len",  rec_len,       32'd0);
      check("mid_rst_overflow", 32'(overflow), 32'd0);
      check("mid_rst_done",     32'(done),     32'd0);
      cyc(2);
      reset_n = 1'b1;
      wr_ack  = 1'b1;
      cyc(1);
      push_hdr();
      start_rec();
      cyc(45);
      check("len_after_restart", rec_len, 32'd0);
      push_patch(32'd0);
      stop_rec();
      wait_done();
      check("drained_final", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global time bound so the run always terminates
   initial begin
      #3000000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
